// File: rtl/edge_detector_window_adr_gen.sv
// Raster-scan address generator for a 3x3 image window: emits 9 neighbour read
// addresses per centre pixel over a valid/ready stream, with skip or clamp borders.
module edge_detector_window_adr_gen #(
  parameter int unsigned IMG_W       = 100,
  parameter int unsigned IMG_H       = 100,
  parameter int unsigned ADR_W       = 16,
  parameter int unsigned BASE_ADR    = 0,
  parameter int unsigned BORDER_MODE = 0,
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic             Clk_i,
  input  logic             Rst_ni,
  input  logic             Start_i,
  input  logic             Abort_i,
  output logic [ADR_W-1:0] Adr_o,
  output logic             AdrValid_o,
  input  logic             AdrReady_i,
  output logic [3:0]       TapIdx_o,
  output logic [XW-1:0]    CenterX_o,
  output logic [YW-1:0]    CenterY_o,
  output logic             LastTap_o,
  output logic             Busy_o,
  output logic             Done_o
);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  localparam bit Clamp    = (BORDER_MODE != 0);
  localparam bit NoCentre = !Clamp && ((IMG_W < 3) || (IMG_H < 3));

  localparam logic [XW-1:0]    XFirst   = Clamp ? XW'(0) : XW'(1);
  localparam logic [XW-1:0]    XLast    = Clamp ? XW'(IMG_W - 1) : XW'(IMG_W - 2);
  localparam logic [XW-1:0]    XMax     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    YFirst   = Clamp ? YW'(0) : YW'(1);
  localparam logic [YW-1:0]    YLast    = Clamp ? YW'(IMG_H - 1) : YW'(IMG_H - 2);
  localparam logic [YW-1:0]    YMax     = YW'(IMG_H - 1);
  localparam logic [ADR_W-1:0] RowStep  = ADR_W'(IMG_W);
  localparam logic [ADR_W-1:0] RowFirst = Clamp ? ADR_W'(0) : ADR_W'(IMG_W);
  localparam logic [ADR_W-1:0] Base     = ADR_W'(BASE_ADR);

  state_e           state_q, state_d;
  logic [3:0]       tap_q, tap_d;
  logic [XW-1:0]    cx_q, cx_d;
  logic [YW-1:0]    cy_q, cy_d;
  // row_q holds cy*IMG_W, kept as a running sum instead of a multiply
  logic [ADR_W-1:0] row_q, row_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_q, last_d;

  logic             hs;
  logic [XW-1:0]    nx;
  logic [ADR_W-1:0] row_sel;

  assign hs = valid_q & AdrReady_i;

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    row_d   = row_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start_i && !Abort_i) begin
          tap_d = 4'd0;
          cx_d  = XFirst;
          cy_d  = YFirst;
          row_d = RowFirst;
          if (NoCentre) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StEmit;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      StEmit: begin
        if (Abort_i) begin
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (hs) begin
          if (tap_q == 4'd8) begin
            tap_d = 4'd0;
            if (cx_q == XLast) begin
              cx_d = XFirst;
              if (cy_q == YLast) begin
                state_d = StDone;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                cy_d  = cy_q + YW'(1);
                row_d = row_q + RowStep;
              end
            end else begin
              cx_d = cx_q + XW'(1);
            end
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Address of the tap that will be presented next; clamping is harmless in skip mode
  always_comb begin
    nx = cx_d;
    case (tap_d)
      4'd0, 4'd3, 4'd6: nx = (cx_d == '0) ? cx_d : cx_d - XW'(1);
      4'd2, 4'd5, 4'd8: nx = (cx_d == XMax) ? cx_d : cx_d + XW'(1);
      default:          nx = cx_d;
    endcase
    row_sel = row_d;
    case (tap_d)
      4'd0, 4'd1, 4'd2: row_sel = (cy_d == '0) ? row_d : row_d - RowStep;
      4'd6, 4'd7, 4'd8: row_sel = (cy_d == YMax) ? row_d : row_d + RowStep;
      default:          row_sel = row_d;
    endcase
    adr_d  = Base + row_sel + ADR_W'(nx);
    last_d = valid_d && (tap_d == 4'd8);
  end

  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q <= StIdle;
      tap_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      row_q   <= '0;
      adr_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      row_q   <= row_d;
      adr_q   <= adr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign Adr_o      = adr_q;
  assign AdrValid_o = valid_q;
  assign TapIdx_o   = tap_q;
  assign CenterX_o  = cx_q;
  assign CenterY_o  = cy_q;
  assign LastTap_o  = last_q;
  assign Busy_o     = busy_q;
  assign Done_o     = done_q;

endmodule
